// File: rtl/mem_pkg.sv
// Shared types for the posted-write memory target: write-bus entry layout
// and the array-slot owner encoding used by the arbiter.
package mem_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    // One posted write as it travels through the FIFO.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } mem_wr_t;

    // Who owns the single array access slot this cycle.
    typedef enum logic [1:0] {
        SLOT_IDLE  = 2'd0,
        SLOT_READ  = 2'd1,
        SLOT_DRAIN = 2'd2
    } slot_e;

endpackage

// File: rtl/mem_wr_fifo.sv
// Posted-write FIFO. Holds pending {addr,data} writes in arrival order and
// exposes every entry's address plus a live/valid flag so the owner can
// detect read-after-write hazards against writes not yet in the array.
module mem_wr_fifo
    import mem_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  mem_wr_t                      push_entry,
    input  logic                         pop,
    output mem_wr_t                      head,
    output logic                         full,
    output logic                         empty,
    output logic [LVL_W-1:0]             level,
    output logic [DEPTH-1:0]             ent_valid,
    output logic [DEPTH-1:0][ADDR_W-1:0] ent_addr
);

    mem_wr_t          store_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [LVL_W-1:0] level_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full  = (level_r == LVL_W'(DEPTH));
    assign empty = (level_r == {LVL_W{1'b0}});
    assign level = level_r;
    assign head  = store_r[rd_ptr_r];

    // A push into a full FIFO is only taken when the head leaves this same cycle.
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of 2).
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Entry payload storage; stale slots are masked by ent_valid so no reset is needed.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            store_r[wr_ptr_r] <= push_entry;
        end
    end

    // An entry is live when its distance from the head is below the fill level.
    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        logic [PTR_W-1:0] dist_s;
        assign dist_s       = PTR_W'(g) - rd_ptr_r;
        assign ent_valid[g] = ({1'b0, dist_s} < level_r);
        assign ent_addr[g]  = store_r[g].addr;
    end

endmodule

// File: rtl/mem_slave_buf.sv
// Memory target with posted writes. Incoming writes are buffered in a small
// FIFO and drained into the storage array whenever the single access slot is
// free; reads compete for that slot and wait while any pending write targets
// the same address, so a read never returns data older than an accepted write.
// Address and data widths come from mem_pkg so the FIFO entry type and the
// ports always agree.
module mem_slave_buf
    import mem_pkg::*;
#(
    parameter  int FIFO_DEPTH = 4,
    parameter  int CNT_W      = 8,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [LVL_W-1:0]  fifo_level,
    output logic              wr_ovf,
    output logic [CNT_W-1:0]  drop_cnt
);

    localparam int MEM_DEPTH = 2 ** ADDR_W;

    mem_wr_t                          push_entry_s;
    mem_wr_t                          head_s;
    logic                             full_s;
    logic                             empty_s;
    logic [FIFO_DEPTH-1:0]            ent_valid_s;
    logic [FIFO_DEPTH-1:0][ADDR_W-1:0] ent_addr_s;
    logic                             hazard_s;
    logic                             pop_s;
    logic                             drop_s;
    slot_e                            slot_s;
    logic [DATA_W-1:0]                mem_r [MEM_DEPTH];

    assign push_entry_s.addr = addr;
    assign push_entry_s.data = data;

    mem_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (wr_en),
        .push_entry (push_entry_s),
        .pop        (pop_s),
        .head       (head_s),
        .full       (full_s),
        .empty      (empty_s),
        .level      (fifo_level),
        .ent_valid  (ent_valid_s),
        .ent_addr   (ent_addr_s)
    );

    // Read hazard: the requested address matches any pending write; the write
    // arriving this very cycle is deliberately not part of the compare.
    always_comb begin
        hazard_s = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (ent_valid_s[i] && (ent_addr_s[i] == rd_addr)) begin
                hazard_s = 1'b1;
            end else begin
                hazard_s = hazard_s;
            end
        end
    end

    // Slot arbitration: a full FIFO must drain first, otherwise reads win over drains.
    always_comb begin
        if (full_s && !empty_s) begin
            slot_s = SLOT_DRAIN;
        end else if (rd_req && !hazard_s) begin
            slot_s = SLOT_READ;
        end else if (!empty_s) begin
            slot_s = SLOT_DRAIN;
        end else begin
            slot_s = SLOT_IDLE;
        end
    end

    // Decode the slot owner into grant/pop strobes; a drop is a push into a full FIFO with no drain.
    always_comb begin
        case (slot_s)
            SLOT_READ: begin
                rd_gnt = 1'b1;
                pop_s  = 1'b0;
            end
            SLOT_DRAIN: begin
                rd_gnt = 1'b0;
                pop_s  = 1'b1;
            end
            default: begin
                rd_gnt = 1'b0;
                pop_s  = 1'b0;
            end
        endcase
        drop_s = wr_en && full_s && !pop_s;
    end

    // Storage array: cleared on reset, written only by the FIFO head when draining.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (pop_s) begin
            mem_r[head_s.addr] <= head_s.data;
        end
    end

    // Read return register: one-cycle valid pulse per grant, data held between reads.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_valid <= 1'b0;
            rd_data  <= {DATA_W{1'b0}};
        end else begin
            rd_valid <= rd_gnt;
            if (rd_gnt) begin
                rd_data <= mem_r[rd_addr];
            end
        end
    end

    // Overflow tracking: sticky flag plus a saturating count of dropped writes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ovf   <= 1'b0;
            drop_cnt <= {CNT_W{1'b0}};
        end else if (drop_s) begin
            wr_ovf <= 1'b1;
            if (drop_cnt != {CNT_W{1'b1}}) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end
    end

endmodule
